// File: rtl/dff_array_pipe_pkg.sv
// Shared constants and helpers for the dff_array_pipe delay line.
// The optional build checks are enabled with DFF_ARRAY_PIPE_CHECK_EN.
package dff_array_pipe_pkg;

  localparam int RETIME_OFF = 0;
  localparam int RETIME_ON  = 1;

  function automatic bit dims_valid(input int width, input int size1,
                                    input int size2, input int depth);
    return (width >= 1) && (size1 >= 1) && (size2 >= 1) && (depth >= 0);
  endfunction

endpackage

// File: rtl/dff_array_stage.sv
// One register stage holding a WIDTH x ARRAY_SIZE1 x ARRAY_SIZE2 word array.
// RETIME_STATUS selects a reset-less stage that synthesis may retime.
module dff_array_stage
  import dff_array_pipe_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d [ARRAY_SIZE1][ARRAY_SIZE2],
  output logic [WIDTH-1:0] q [ARRAY_SIZE1][ARRAY_SIZE2]
);

  generate
    if (RETIME_STATUS == RETIME_ON) begin : g_noreset
      always_ff @(posedge clk) begin
        if (en) q <= d;
      end
    end else begin : g_reset
      always_ff @(posedge clk) begin
        if (reset)   q <= '{default: '0};
        else if (en) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/dff_array_pipe.sv
// PIPE_DEPTH-stage delay line for a 2-D word array with global enable.
// Define DFF_ARRAY_PIPE_CHECK_EN for parameter checks and an X-propagation assertion.
module dff_array_pipe
  import dff_array_pipe_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in  [ARRAY_SIZE1][ARRAY_SIZE2],
  output logic [WIDTH-1:0] out [ARRAY_SIZE1][ARRAY_SIZE2]
);

`ifdef DFF_ARRAY_PIPE_CHECK_EN
  generate
    if (!dims_valid(WIDTH, ARRAY_SIZE1, ARRAY_SIZE2, PIPE_DEPTH)) begin : g_bad_params
      $fatal(1, "dff_array_pipe: WIDTH/ARRAY_SIZE1/ARRAY_SIZE2 must be >= 1 and PIPE_DEPTH >= 0");
    end
  endgenerate
`endif

  generate
    if (PIPE_DEPTH == 0) begin : g_passthru
      assign out = in;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [PIPE_DEPTH][ARRAY_SIZE1][ARRAY_SIZE2];

      for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
          dff_array_stage #(
            .WIDTH         (WIDTH),
            .ARRAY_SIZE1   (ARRAY_SIZE1),
            .ARRAY_SIZE2   (ARRAY_SIZE2),
            .RETIME_STATUS (RETIME_STATUS)
          ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (in),
            .q     (stage_q[k])
          );
        end else begin : g_next
          dff_array_stage #(
            .WIDTH         (WIDTH),
            .ARRAY_SIZE1   (ARRAY_SIZE1),
            .ARRAY_SIZE2   (ARRAY_SIZE2),
            .RETIME_STATUS (RETIME_STATUS)
          ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (stage_q[k-1]),
            .q     (stage_q[k])
          );
        end
      end

      assign out = stage_q[PIPE_DEPTH-1];

`ifdef DFF_ARRAY_PIPE_CHECK_EN
      // clean_hist tracks, per enabled cycle, whether the captured input was
      // fully known; reset clears it so the check only arms after a full refill.
      logic clean_hist [PIPE_DEPTH];
      logic in_clean;
      logic out_clean;

      always_comb begin
        in_clean  = 1'b1;
        out_clean = 1'b1;
        for (int unsigned i = 0; i < ARRAY_SIZE1; i++) begin
          for (int unsigned j = 0; j < ARRAY_SIZE2; j++) begin
            if ($isunknown(in[i][j]))  in_clean  = 1'b0;
            if ($isunknown(out[i][j])) out_clean = 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          clean_hist <= '{default: 1'b0};
        end else if (en) begin
          clean_hist[0] <= in_clean;
          for (int unsigned k = 1; k < PIPE_DEPTH; k++) clean_hist[k] <= clean_hist[k-1];
        end
      end

      always @(negedge clk) begin
        if (RETIME_STATUS == RETIME_OFF && !reset && clean_hist[PIPE_DEPTH-1])
          assert (out_clean) else $error("dff_array_pipe: X/Z on out from known input");
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_dff_array_pipe.sv
// Directed self-checking bench for dff_array_pipe: latency, reset, stall,
// depth alignment, scalar flag and zero-depth pass-through.
module tb_dff_array_pipe;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic [23:0] din      [3][3];
  logic [23:0] dout_d3  [3][3];
  logic [23:0] dout_d2  [3][3];
  logic        fin      [1][1];
  logic        fout     [1][1];
  logic        pout     [1][1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_array_pipe #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(0))
    u_d3 (.clk(clk), .reset(reset), .en(en), .in(din), .out(dout_d3));

  dff_array_pipe #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(2), .RETIME_STATUS(0))
    u_d2 (.clk(clk), .reset(reset), .en(en), .in(din), .out(dout_d2));

  dff_array_pipe #(.WIDTH(1), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(3), .RETIME_STATUS(0))
    u_flag (.clk(clk), .reset(reset), .en(en), .in(fin), .out(fout));

  dff_array_pipe #(.WIDTH(1), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(0))
    u_pass (.clk(clk), .reset(reset), .en(en), .in(fin), .out(pout));

  function automatic logic [23:0] pat(input int i, input int j, input int c);
    return 24'(16 * i + j + c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [23:0] v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) din[i][j] = v;
  endtask

  task automatic set_pat(input int c);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) din[i][j] = pat(i, j, c);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; set_all(24'h000005); fin[0][0] = 1'b1;
    step(); step();
    fin[0][0] = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (dout_d3[i][j] !== 24'h0) begin
          n_fail++; $display("FAIL reset_d3[%0d][%0d] got %h want 000000", i, j, dout_d3[i][j]);
        end
        n_checks++;
        if (dout_d2[i][j] !== 24'h0) begin
          n_fail++; $display("FAIL reset_d2[%0d][%0d] got %h want 000000", i, j, dout_d2[i][j]);
        end
      end
    n_checks++;
    if (fout[0][0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_flag got %b want 0", fout[0][0]);
    end
  endtask

  task automatic test_latency();
    logic [23:0] e3, e2;
    reset = 1'b0; en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      set_pat(c);
      step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          e3 = (c >= 3) ? pat(i, j, c - 2) : 24'h0;
          e2 = (c >= 2) ? pat(i, j, c - 1) : 24'h0;
          n_checks++;
          if (dout_d3[i][j] !== e3) begin
            n_fail++; $display("FAIL latency_d3 c=%0d [%0d][%0d] got %h want %h", c, i, j, dout_d3[i][j], e3);
          end
          n_checks++;
          if (dout_d2[i][j] !== e2) begin
            n_fail++; $display("FAIL latency_d2 c=%0d [%0d][%0d] got %h want %h", c, i, j, dout_d2[i][j], e2);
          end
        end
    end
  endtask

  task automatic test_alignment();
    logic [23:0] a, b;
    a = 24'hA5A5A5; b = 24'h5A5A5A;
    set_all(a);
    repeat (4) step();
    set_all(b);
    for (int s = 0; s < 3; s++) begin
      step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (dout_d2[i][j] !== ((s >= 1) ? b : a)) begin
            n_fail++; $display("FAIL align_d2 s=%0d got %h want %h", s, dout_d2[i][j], (s >= 1) ? b : a);
          end
          n_checks++;
          if (dout_d3[i][j] !== ((s >= 2) ? b : a)) begin
            n_fail++; $display("FAIL align_d3 s=%0d got %h want %h", s, dout_d3[i][j], (s >= 2) ? b : a);
          end
          n_checks++;
          if ((dout_d3[i][j] !== dout_d2[i][j]) !== (s == 1)) begin
            n_fail++; $display("FAIL align_diff s=%0d d3=%h d2=%h want differ=%0d", s, dout_d3[i][j], dout_d2[i][j], s == 1);
          end
        end
    end
  endtask

  task automatic test_reset_clear();
    set_all(24'hFFFFFF);
    repeat (5) step();
    n_checks++;
    if (dout_d3[2][2] !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL clear_preload got %h want ffffff", dout_d3[2][2]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (dout_d3[i][j] !== ((s == 3) ? 24'hFFFFFF : 24'h0)) begin
            n_fail++; $display("FAIL clear_d3 s=%0d [%0d][%0d] got %h want %h", s, i, j, dout_d3[i][j], (s == 3) ? 24'hFFFFFF : 24'h0);
          end
          n_checks++;
          if (dout_d2[i][j] !== ((s >= 2) ? 24'hFFFFFF : 24'h0)) begin
            n_fail++; $display("FAIL clear_d2 s=%0d [%0d][%0d] got %h want %h", s, i, j, dout_d2[i][j], (s >= 2) ? 24'hFFFFFF : 24'h0);
          end
        end
    end
  endtask

  task automatic test_reset_priority();
    set_all(24'h123456);
    reset = 1'b1; en = 1'b1;
    step();
    reset = 1'b0; en = 1'b0; set_all(24'h0);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (dout_d3[i][j] !== 24'h0) begin
            n_fail++; $display("FAIL prio_d3 s=%0d [%0d][%0d] got %h want 000000", s, i, j, dout_d3[i][j]);
          end
          n_checks++;
          if (dout_d2[i][j] !== 24'h0) begin
            n_fail++; $display("FAIL prio_d2 s=%0d [%0d][%0d] got %h want 000000", s, i, j, dout_d2[i][j]);
          end
        end
    end
  endtask

  task automatic test_stall();
    reset = 1'b1; en = 1'b1;
    step();
    reset = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      set_all(24'(v));
      step();
    end
    en = 1'b0; set_all(24'd99);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) step();
      n_checks++;
      if (dout_d2[1][2] !== 24'd2) begin
        n_fail++; $display("FAIL stall_hold_d2 s=%0d got %0d want 2", s, dout_d2[1][2]);
      end
      n_checks++;
      if (dout_d3[2][0] !== 24'd1) begin
        n_fail++; $display("FAIL stall_hold_d3 s=%0d got %0d want 1", s, dout_d3[2][0]);
      end
    end
    en = 1'b1;
    for (int v = 4; v <= 6; v++) begin
      set_all(24'(v));
      step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (dout_d2[i][j] !== 24'(v - 1)) begin
            n_fail++; $display("FAIL stall_resume_d2 v=%0d got %0d want %0d", v, dout_d2[i][j], v - 1);
          end
          n_checks++;
          if (dout_d3[i][j] !== 24'(v - 2)) begin
            n_fail++; $display("FAIL stall_resume_d3 v=%0d got %0d want %0d", v, dout_d3[i][j], v - 2);
          end
        end
    end
  endtask

  task automatic test_flag();
    reset = 1'b1; en = 1'b1; fin[0][0] = 1'b0;
    step();
    reset = 1'b0; fin[0][0] = 1'b1;
    step();
    fin[0][0] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) step();
      n_checks++;
      if (fout[0][0] !== (s == 2)) begin
        n_fail++; $display("FAIL flag_pulse s=%0d got %b want %b", s, fout[0][0], s == 2);
      end
    end
  endtask

  task automatic test_passthrough();
    logic pattern [4];
    pattern = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int s = 0; s < 4; s++) begin
      reset = (s >= 2);
      fin[0][0] = pattern[s];
      #1;
      n_checks++;
      if (pout[0][0] !== pattern[s]) begin
        n_fail++; $display("FAIL pass_comb s=%0d got %b want %b", s, pout[0][0], pattern[s]);
      end
    end
    step();
    n_checks++;
    if (pout[0][0] !== 1'b1) begin
      n_fail++; $display("FAIL pass_reset got %b want 1", pout[0][0]);
    end
    fin[0][0] = 1'b0;
    #1;
    n_checks++;
    if (pout[0][0] !== 1'b0) begin
      n_fail++; $display("FAIL pass_reset_low got %b want 0", pout[0][0]);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; set_all(24'h0); fin[0][0] = 1'b0;
    test_reset();
    test_latency();
    test_alignment();
    test_reset_clear();
    test_reset_priority();
    test_stall();
    test_flag();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
